axi_stream_packer: RTL and testbench

- Downstream neighbour of the increment pipeline stage: consumes its DWIDTH-bit valid/ready stream.
- Packs RATIO consecutive beats into one wide word for wider downstream logic.
- An upstream end-of-frame flag closes a partial word early; lane-enable and last flags describe each output word.
- Single clock domain, one output holding register, full throughput when the sink is ready.

---
 rtl/axi_stream_packer_pkg.sv | 27 ++
 rtl/axi_stream_packer.sv | 85 ++++++++
 tb/tb_axi_stream_packer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_packer_pkg.sv
// Shared constants and helpers for the stream packer: counter sizing and
// lane-to-bit-offset mapping.
package axi_stream_packer_pkg;

  localparam int DEFAULT_RATIO = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Beat counter width; at least one bit so the counter is never zero-width.
  function automatic int cnt_width(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DEFAULT_RATIO);

  // Little-endian lane placement: lane k starts at bit k*dwidth.
  function automatic int lane_lsb(input int lane, input int dwidth);
    return lane * dwidth;
  endfunction

endpackage

// File: rtl/axi_stream_packer.sv
// Packs RATIO narrow valid/ready beats into one wide word, closing a word early
// on an end-of-frame beat; a single output holding register gives full throughput.
module axi_stream_packer
  import axi_stream_packer_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RATIO  = DEFAULT_RATIO
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  output logic                     ready_o,
  input  logic                     valid_i,
  input  logic [DWIDTH-1:0]        data_i,
  input  logic                     last_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DWIDTH*RATIO-1:0]  data_o,
  output logic [RATIO-1:0]         keep_o,
  output logic                     last_o
);

  localparam int              CNT_W   = cnt_width(RATIO);
  localparam int              OW      = DWIDTH * RATIO;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt;
  logic [OW-1:0]    acc;
  logic [RATIO-1:0] mask;
  logic [OW-1:0]    acc_ins;
  logic [RATIO-1:0] mask_ins;
  logic             in_fire;
  logic             out_fire;
  logic             complete;

  // The output register can take a new word whenever it is empty or draining.
  assign ready_o  = areset_i & (~valid_o | ready_i);
  assign in_fire  = ready_o & valid_i;
  assign out_fire = valid_o & ready_i;
  assign complete = in_fire & ((cnt == CNT_MAX) | last_i);

  always_comb begin
    // NOTE: every variable gets a default before any conditional write,
    // otherwise the tool infers a latch to hold the old value.
    acc_ins  = acc;
    mask_ins = mask | (RATIO'(1) << cnt);
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) acc_ins[lane_lsb(k, DWIDTH) +: DWIDTH] = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk_i) begin
    if (!areset_i) begin
      // NOTE: the accumulator is reset explicitly because unused upper lanes
      // are emitted as zeros when a frame closes early.
      cnt     <= '0;
      acc     <= '0;
      mask    <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
    end else begin
      if (out_fire) valid_o <= 1'b0;
      if (in_fire) begin
        if (complete) begin
          // Overrides the drain above, so back-to-back words leave no bubble.
          data_o  <= acc_ins;
          keep_o  <= mask_ins;
          last_o  <= last_i;
          valid_o <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
          mask    <= '0;
        end else begin
          acc  <= acc_ins;
          mask <= mask_ins;
          cnt  <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_packer.sv
// Randomised and directed bench for axi_stream_packer; a frame-level model
// predicts packed words into a queue that an output monitor drains.
module tb_axi_stream_packer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int OW = DW * R;

  typedef struct {
    logic [OW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } word_t;

  logic          aclk_i = 1'b0;
  logic          areset_i;
  logic          ready_o;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          last_i;
  logic          ready_i;
  logic          valid_o;
  logic [OW-1:0] data_o;
  logic [R-1:0]  keep_o;
  logic          last_o;

  int    checks = 0;
  int    errors = 0;
  int    words_seen = 0;
  bit    rand_phase = 1'b0;
  word_t exp_q[$];
  logic [DW-1:0] part[$];

  axi_stream_packer #(.DWIDTH(DW), .RATIO(R)) dut (
    .aclk_i(aclk_i), .areset_i(areset_i), .ready_o(ready_o),
    .valid_i(valid_i), .data_i(data_i), .last_i(last_i),
    .ready_i(ready_i), .valid_o(valid_o), .data_o(data_o),
    .keep_o(keep_o), .last_o(last_o)
  );

  always #5 aclk_i = ~aclk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted beats of the current word; a word closes
  // when it holds R beats or an end-of-frame beat arrives.
  always @(negedge aclk_i) begin
    if (!areset_i) begin
      part.delete();
      exp_q.delete();
    end else if (ready_o && valid_i) begin
      part.push_back(data_i);
      if (part.size() == R || last_i) begin
        word_t w;
        w.data = '0;
        for (int i = 0; i < part.size(); i++) w.data[i*DW +: DW] = part[i];
        w.keep = R'((1 << part.size()) - 1);
        w.last = last_i;
        exp_q.push_back(w);
        part.delete();
      end
    end
  end

  // Output monitor: compares on every out_fire and checks stability under stall.
  logic          hold_prev = 1'b0;
  logic [OW-1:0] data_prev;
  logic [R-1:0]  keep_prev;
  logic          last_prev;
  always @(negedge aclk_i) begin
    if (areset_i) begin
      if (hold_prev) begin
        check("stall_valid", 64'(valid_o), 64'd1);
        check("stall_data",  64'(data_o),  64'(data_prev));
        check("stall_keep",  64'(keep_o),  64'(keep_prev));
        check("stall_last",  64'(last_o),  64'(last_prev));
      end
      if (valid_o && ready_i) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(data_o), 64'hDEAD_BEEF_0000);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("word_data", 64'(data_o), 64'(w.data));
          check("word_keep", 64'(keep_o), 64'(w.keep));
          check("word_last", 64'(last_o), 64'(w.last));
        end
      end
    end
    hold_prev = areset_i && valid_o && !ready_i;
    data_prev = data_o;
    keep_prev = keep_o;
    last_prev = last_o;
  end

  // Random sink behaviour during the random phase only.
  always @(posedge aclk_i) begin
    if (rand_phase) begin
      #1 ready_i = ($urandom_range(0, 99) < 60);
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done;
    done    = 1'b0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk_i);
      if (ready_o) done = 1'b1;
    end
    if (!done) check("accept_timeout", 64'd0, 64'd1);
    @(posedge aclk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk_i);
    #1;
  endtask

  initial begin
    int base;
    logic [OW-1:0] held;
    areset_i = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    last_i   = 1'b0;
    ready_i  = 1'b1;

    // Reset state
    repeat (2) @(posedge aclk_i);
    @(negedge aclk_i);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data",  64'(data_o),  64'd0);
    check("rst_keep",  64'(keep_o),  64'd0);
    check("rst_last",  64'(last_o),  64'd0);
    @(posedge aclk_i);
    #1 areset_i = 1'b1;
    idle(1);

    // Full word: result appears exactly one cycle after the fourth accept
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    check("full_not_early", 64'(valid_o), 64'd0);
    send(8'h44, 0);
    check("full_valid_latency", 64'(valid_o), 64'd1);
    check("full_data", 64'(data_o), 64'h4433_2211);
    idle(1);
    check("full_valid_one_cycle", 64'(valid_o), 64'd0);

    // Early close, then next beat lands in lane 0
    send(8'hA1, 0); send(8'hA2, 1);
    check("early_data", 64'(data_o), 64'h0000_A2A1);
    check("early_keep", 64'(keep_o), 64'h3);
    send(8'h07, 0); send(8'h08, 0); send(8'h09, 0); send(8'h0A, 0);
    idle(2);

    // Backpressure with a valid word held and upstream pushing
    ready_i = 1'b0;
    send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
    held = data_o;
    valid_i = 1'b1;
    data_i  = 8'hC1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk_i);
      check("bp_ready_low", 64'(ready_o), 64'd0);
      check("bp_data_hold", 64'(data_o), 64'(held));
    end
    @(posedge aclk_i);
    #1 ready_i = 1'b1;
    @(negedge aclk_i);
    check("bp_resume_ready", 64'(ready_o), 64'd1);
    check("bp_resume_valid", 64'(valid_o), 64'd1);
    send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
    idle(2);

    // Back-to-back: two words, one per four cycles
    base = words_seen;
    for (int i = 1; i <= 8; i++) send(DW'(i), 0);
    idle(3);
    check("b2b_word_count", 64'(words_seen - base), 64'd2);

    // Reset mid-word discards the partial 0x55/0x66
    send(8'h55, 0); send(8'h66, 0);
    areset_i = 1'b0;
    @(negedge aclk_i);
    check("midrst_ready", 64'(ready_o), 64'd0);
    @(posedge aclk_i);
    #1 areset_i = 1'b1;
    base = words_seen;
    for (int i = 1; i <= 4; i++) send(DW'(i), 0);
    check("midrst_data", 64'(data_o), 64'h0403_0201);
    check("midrst_keep", 64'(keep_o), 64'hF);
    idle(2);
    check("midrst_word_count", 64'(words_seen - base), 64'd1);

    // Single-beat frame
    send(8'h5A, 1);
    check("single_data", 64'(data_o), 64'h0000_005A);
    check("single_keep", 64'(keep_o), 64'h1);
    check("single_last", 64'(last_o), 64'd1);
    idle(2);

    // Random traffic against the model
    rand_phase = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(DW'($urandom), ($urandom_range(0, 4) == 0));
    end
    rand_phase = 1'b0;
    @(posedge aclk_i);
    #2 ready_i = 1'b1;
    idle(10);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
